k12a_spi_target: RTL and testbench
==================================

# k12a_spi_target

SPI target (responder) peripheral for the k12a I/O space: the far end of the SPI master links that k12a drives. An external SPI controller clocks bytes in and out over mode-0 SPI. The CPU exchanges bytes with it through single-byte receive and transmit buffers, accessed over the shared tri-state `data_bus` with `io_load`/`io_store`-style strobes. All external SPI signals are oversampled on `cpu_clock`; nothing runs on SCK.

## Interface
Parameters: none.

- `cpu_clock` in 1 — the single clock; all state updates on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `spi_sck` in 1 — external SPI clock, asynchronous.
- `spi_cs_n` in 1 — external chip select, active low, asynchronous.
- `spi_mosi` in 1 — serial data in, asynchronous.
- `spi_miso` out 1 — serial data out; driven 0 while deselected, never high-Z.
- `data_bus` inout 8 — shared CPU bus; high-Z unless a load strobe is active.
- `spi_data_io_load` in 1 — CPU read of the RX buffer.
- `spi_data_io_store` in 1 — CPU write of the TX buffer from `data_bus`.
- `spi_status_io_load` in 1 — CPU read of status.

## Operation
- Input synchronisation:
  - `spi_sck`, `spi_cs_n` and `spi_mosi` each pass through a 2-FF synchroniser.
  - A third SCK stage and a third CS stage give edge detection: sck_rise, sck_fall, cs_fall, cs_rise.
- States: IDLE (synchronised CS high) and ACTIVE (synchronised CS low).
- IDLE → ACTIVE on cs_fall:
  - bit_count = 0.
  - tx_shift = tx_buffer if tx_full, else 8'h00.
  - tx_full cleared if the buffer was taken.
- In ACTIVE, on sck_rise:
  - rx_shift = {rx_shift[6:0], mosi_sync}.
  - bit_count increments mod 8 (3-bit counter).
- Byte completion (8th sck_rise, count wraps 7→0):
  - rx_buffer = completed byte and rx_full = 1.
  - If rx_full was already 1 and is not being read in the same cycle: overrun = 1. The new byte overwrites the old one.
- In ACTIVE, on sck_fall:
  - bit_count == 0 (byte boundary): reload tx_shift from tx_buffer, or 8'h00 if not tx_full; clear tx_full.
  - Otherwise: tx_shift = {tx_shift[6:0], 1'b0}.
- `spi_miso` = tx_shift[7] in ACTIVE; 0 in IDLE.
- ACTIVE → IDLE on cs_rise:
  - A partial byte (bit_count ≠ 0) is discarded; rx_full is not set.
  - bit_count = 0.
  - tx_buffer and tx_full are kept.
- CPU side:
  - `spi_data_io_store`: tx_buffer = data_bus, tx_full = 1. Overwrites unconditionally.
  - `spi_data_io_load`: drive rx_buffer onto data_bus combinationally; rx_full cleared at the clock edge.
  - `spi_status_io_load`: drive {4'h0, cs_active, overrun, tx_full, rx_full}; overrun cleared at the clock edge.
  - The load strobes are mutually exclusive by decode. If both are asserted, `data_bus` is driven by rx_buffer only.
- Simultaneous events:
  - Byte completion + data load in the same cycle: the bus shows the old byte; rx_buffer takes the new byte; rx_full = 1; no overrun.
  - TX reload + data store in the same cycle: tx_shift takes the old tx_buffer content (or 8'h00 if it was empty); tx_buffer takes the new value; tx_full = 1.
  - Byte completion + status read: overrun set by this completion wins over the clear.
- Reset (any time, including mid-byte):
  - Buffers, shifts, bit_count, rx_full, tx_full and overrun = 0.
  - State = IDLE, `spi_miso` = 0, `data_bus` high-Z.
  - Synchronisers reset to idle levels (sck 0, cs_n 1, mosi 0).
  - If CS is low at reset release, the synchronised cs_fall produces a normal IDLE→ACTIVE transition.

## Timing
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- External edge to internal action: 3 cpu_clock edges (2 sync + 1 register update).
- MISO changes 3 cpu_clock edges after an external SCK fall or CS fall.
- rx_full is visible 3 edges after the 8th external SCK rise.
- Required external timing: SCK high time ≥ 4 cpu_clock periods; SCK low time ≥ 4; CS fall to first SCK rise ≥ 4; last SCK fall to CS rise ≥ 4. Behaviour outside these limits is undefined.
- CPU bus: load data is valid combinationally in the strobe cycle. Store and flag updates take effect at the end of that cycle.

## Test plan
- Preload via store 8'hA5. Controller sends 8'h3C over 8 SCK cycles with CS low. → MISO bits 1,0,1,0,0,1,0,1; rx_buffer = 8'h3C; status = 8'h09 (cs_active, rx_full), becoming 8'h01 after CS rise; tx_full = 0.
- Two back-to-back bytes under one CS: 8'h11 then 8'h22, TX 8'hC3 loaded only before the first. → Second byte's MISO = 8'h00. No read in between → overrun = 1 and rx_buffer = 8'h22. A status read returns overrun = 1, the next read returns 0.
- CS rises after 5 SCK cycles. → rx_full stays 0 and bit_count resets. The next full byte 8'h7E is received correctly.
- Data load in the same cycle as byte completion → bus shows the old byte; rx_full stays 1; overrun stays 0.
- Store 8'h5A in the same cycle as the byte-boundary reload, with tx_buffer = 8'h99 → next byte shifts out 8'h99; tx_buffer = 8'h5A with tx_full = 1.
- Assert reset mid-byte → all flags 0, `spi_miso` = 0, `data_bus` high-Z. After CS toggles, the next byte is received cleanly.

Source files
------------

// File: rtl/k12a_spi_target.sv
// Mode-0 SPI target for the k12a I/O space. SCK, CS and MOSI are oversampled on
// cpu_clock, and bytes move through single-byte RX and TX buffers on the shared CPU bus.
module k12a_spi_target (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  inout  wire  [7:0] data_bus,
  input  logic       spi_data_io_load,
  input  logic       spi_data_io_store,
  input  logic       spi_status_io_load
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state;
  logic [2:0] sck_q, cs_q;
  logic [1:0] mosi_q;
  logic [2:0] bit_count;
  logic [7:0] rx_shift, tx_shift, rx_buffer, tx_buffer;
  logic       rx_full, tx_full, overrun;

  logic sck_rise, sck_fall, cs_fall, cs_rise;
  logic active, byte_done, take_tx;
  logic [7:0] status;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign active   = (state == ACTIVE);

  // A CS rise in the same cycle as a SCK edge ends the transfer and drops the edge.
  assign byte_done = active && !cs_rise && sck_rise && (bit_count == 3'd7);
  assign take_tx   = (!active && cs_fall) ||
                     (active && !cs_rise && sck_fall && (bit_count == 3'd0));

  assign status   = {4'h0, active, overrun, tx_full, rx_full};
  assign spi_miso = active & tx_shift[7];

  // The data load wins the bus if both load strobes are asserted.
  assign data_bus = spi_data_io_load   ? rx_buffer :
                    spi_status_io_load ? status    : 8'hzz;

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      state     <= IDLE;
      sck_q     <= 3'b000;
      cs_q      <= 3'b111;
      mosi_q    <= 2'b00;
      bit_count <= 3'd0;
      rx_shift  <= 8'h00;
      tx_shift  <= 8'h00;
      rx_buffer <= 8'h00;
      tx_buffer <= 8'h00;
      rx_full   <= 1'b0;
      tx_full   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      cs_q   <= {cs_q[1:0], spi_cs_n};
      mosi_q <= {mosi_q[0], spi_mosi};

      // The reload sees the pre-store buffer, so a same-cycle store lands in the next byte.
      if (take_tx)
        tx_shift <= tx_full ? tx_buffer : 8'h00;
      if (spi_data_io_store)
        tx_buffer <= data_bus;
      tx_full <= spi_data_io_store | (tx_full & ~take_tx);

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= ACTIVE;
            bit_count <= 3'd0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state     <= IDLE;
            bit_count <= 3'd0;
          end else if (sck_rise) begin
            rx_shift  <= {rx_shift[6:0], mosi_q[1]};
            bit_count <= bit_count + 3'd1;
          end else if (sck_fall && bit_count != 3'd0) begin
            tx_shift  <= {tx_shift[6:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase

      if (byte_done) begin
        rx_buffer <= {rx_shift[6:0], mosi_q[1]};
        rx_full   <= 1'b1;
      end else if (spi_data_io_load) begin
        rx_full   <= 1'b0;
      end

      // An overrun raised by this completion beats a same-cycle status-read clear.
      if (byte_done && rx_full && !spi_data_io_load)
        overrun <= 1'b1;
      else if (spi_status_io_load)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_k12a_spi_target.sv
// Scoreboard bench for k12a_spi_target. Stimulus queues the expected bus and MISO values.
// Monitors pop and compare those values whenever the DUT presents data.
module tb_k12a_spi_target;

  logic cpu_clock = 1'b0;
  logic reset = 1'b1;
  logic spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic spi_data_io_load = 1'b0, spi_data_io_store = 1'b0, spi_status_io_load = 1'b0;
  logic spi_miso;
  wire [7:0] data_bus;
  logic [7:0] drv = 8'h00;
  logic drv_en = 1'b0;
  logic probe = 1'b0;
  logic chk_miso = 1'b0;

  int checks = 0;
  int passes = 0;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t bus_q[$];
  exp_t miso_q[$];
  exp_t idle_q[$];

  always #5 cpu_clock = ~cpu_clock;

  // The pullups make an undriven bus read as 8'hFF.
  assign data_bus = drv_en ? drv : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (data_bus[i]);
  end

  k12a_spi_target dut (
    .cpu_clock          (cpu_clock),
    .reset              (reset),
    .spi_sck            (spi_sck),
    .spi_cs_n           (spi_cs_n),
    .spi_mosi           (spi_mosi),
    .spi_miso           (spi_miso),
    .data_bus           (data_bus),
    .spi_data_io_load   (spi_data_io_load),
    .spi_data_io_store  (spi_data_io_store),
    .spi_status_io_load (spi_status_io_load)
  );

  function automatic exp_t mk(input string name, input logic [7:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    return e;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %02h, want %02h", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: no expected value queued", name);
  endtask

  // Bus and idle monitor: it samples on the negedge, mid-cycle of each strobe.
  always @(negedge cpu_clock) begin : mon_bus
    exp_t e;
    if (spi_data_io_load || spi_status_io_load) begin
      if (bus_q.size() == 0) fail("bus_underflow");
      else begin
        e = bus_q.pop_front();
        check(e.name, data_bus, e.val);
      end
    end
    if (probe) begin
      if (idle_q.size() == 0) fail("idle_underflow");
      else begin
        e = idle_q.pop_front();
        check({e.name, "_bus"}, data_bus, e.val);
        check({e.name, "_miso"}, {7'b0, spi_miso}, 8'h00);
      end
    end
  end

  // MISO monitor: it samples where a mode-0 controller would, on the SCK rise.
  always @(posedge spi_sck) begin : mon_miso
    exp_t e;
    if (chk_miso) begin
      if (miso_q.size() == 0) fail("miso_underflow");
      else begin
        e = miso_q.pop_front();
        check(e.name, {7'b0, spi_miso}, e.val);
      end
    end
  end

  task automatic steps(input int n);
    repeat (n) begin
      @(posedge cpu_clock);
      #1;
    end
  endtask

  task automatic cpu_store(input logic [7:0] v);
    drv = v; drv_en = 1'b1; spi_data_io_store = 1'b1;
    steps(1);
    spi_data_io_store = 1'b0; drv_en = 1'b0;
  endtask

  task automatic rd_data(input string name, input logic [7:0] v);
    bus_q.push_back(mk(name, v));
    spi_data_io_load = 1'b1;
    steps(1);
    spi_data_io_load = 1'b0;
  endtask

  task automatic rd_status(input string name, input logic [7:0] v);
    bus_q.push_back(mk(name, v));
    spi_status_io_load = 1'b1;
    steps(1);
    spi_status_io_load = 1'b0;
  endtask

  task automatic probe_idle(input string name);
    idle_q.push_back(mk(name, 8'hFF));
    probe = 1'b1;
    steps(1);
    probe = 1'b0;
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    steps(5);
  endtask

  task automatic cs_end();
    steps(5);
    spi_cs_n = 1'b1;
    steps(5);
  endtask

  // hook 1: data load in the completion cycle of the last rise (hv = expected old byte)
  // hook 2: store hv in the reload cycle of the last fall
  task automatic spi_bits(input logic [7:0] b, input int n, input logic chk,
                          input logic [7:0] mexp, input int hook, input logic [7:0] hv);
    chk_miso = chk;
    for (int i = 0; i < n; i++) begin
      if (chk) miso_q.push_back(mk($sformatf("miso_%02h_b%0d", mexp, 7 - i), {7'b0, mexp[7 - i]}));
      spi_mosi = b[7 - i];
      steps(4);
      spi_sck = 1'b1;
      steps(2);
      if (hook == 1 && i == n - 1) begin
        bus_q.push_back(mk("load_at_done", hv));
        spi_data_io_load = 1'b1;
      end
      steps(1);
      spi_data_io_load = 1'b0;
      steps(2);
      spi_sck = 1'b0;
      steps(2);
      if (hook == 2 && i == n - 1) begin
        drv = hv; drv_en = 1'b1; spi_data_io_store = 1'b1;
      end
      steps(1);
      spi_data_io_store = 1'b0; drv_en = 1'b0;
      steps(2);
    end
    chk_miso = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic [7:0] mexp);
    spi_bits(b, 8, 1'b1, mexp, 0, 8'h00);
  endtask

  initial begin
    steps(3);
    reset = 1'b0;
    probe_idle("reset");
    rd_status("reset_status", 8'h00);

    // Preloaded byte goes out while 3C comes in
    cpu_store(8'hA5);
    rd_status("t1_preload", 8'h02);
    cs_begin();
    spi_byte(8'h3C, 8'hA5);
    rd_status("t1_active", 8'h09);
    cs_end();
    rd_status("t1_idle", 8'h01);
    rd_data("t1_rx", 8'h3C);
    rd_status("t1_clear", 8'h00);

    // Two bytes under one CS: the second sends 00, and the unread first byte overruns
    cpu_store(8'hC3);
    cs_begin();
    spi_byte(8'h11, 8'hC3);
    spi_byte(8'h22, 8'h00);
    cs_end();
    rd_status("t2_overrun", 8'h05);
    rd_status("t2_overrun_clr", 8'h01);
    rd_data("t2_rx", 8'h22);
    rd_status("t2_clear", 8'h00);

    // A partial byte is discarded
    cs_begin();
    spi_bits(8'hAA, 5, 1'b0, 8'h00, 0, 8'h00);
    cs_end();
    rd_status("t3_partial", 8'h00);
    cs_begin();
    spi_byte(8'h7E, 8'h00);
    cs_end();
    rd_data("t3_rx", 8'h7E);

    // Data load collides with byte completion
    cs_begin();
    spi_byte(8'h81, 8'h00);
    spi_bits(8'h42, 8, 1'b1, 8'h00, 1, 8'h81);
    cs_end();
    rd_status("t4_status", 8'h01);
    rd_data("t4_rx", 8'h42);
    rd_status("t4_clear", 8'h00);

    // Store collides with the byte-boundary reload
    cs_begin();
    cpu_store(8'h99);
    spi_bits(8'h10, 8, 1'b1, 8'h00, 2, 8'h5A);
    rd_status("t5_txfull", 8'h0B);
    rd_data("t5_rx0", 8'h10);
    spi_byte(8'h20, 8'h99);
    rd_data("t5_rx1", 8'h20);
    spi_byte(8'h30, 8'h5A);
    cs_end();
    rd_status("t5_status", 8'h01);
    rd_data("t5_rx2", 8'h30);

    // Reset mid-byte while CS stays low
    cpu_store(8'hE7);
    cs_begin();
    spi_bits(8'hF0, 4, 1'b0, 8'h00, 0, 8'h00);
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    probe_idle("t6_reset");
    rd_status("t6_status", 8'h00);
    spi_cs_n = 1'b1;
    steps(5);
    cs_begin();
    spi_byte(8'h5C, 8'h00);
    cs_end();
    rd_data("t6_rx", 8'h5C);
    rd_status("t6_clear", 8'h00);

    steps(2);
    checks++;
    if (bus_q.size() == 0 && miso_q.size() == 0 && idle_q.size() == 0) passes++;
    else $display("FAIL queues_drained: bus %0d miso %0d idle %0d left, want 0",
                  bus_q.size(), miso_q.size(), idle_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
